dm_access_ctrl: RTL

Pipeline-side initiator for the word-wide data memory. Accepts one load/store request at a time from the MEM stage and drives the memory's read/write/address/data ports. Sub-word stores are performed as read-modify-write, because the memory only writes whole words. Load data is returned sign- or zero-extended. The MEM stage holds on `req_ready`=0.

---
 rtl/dm_access_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: single outstanding load/store toward a
// word-wide memory; sub-word stores use read-modify-write, loads are extended.
module dm_access_ctrl #(
    parameter int unsigned DM_ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 DM_read,
    output logic                 DM_write,
    output logic [DM_ADDR_W-1:0] DM_addr,
    output logic [31:0]          DM_in,
    input  logic [31:0]          DM_out
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_DATA,
        ST_WR,
        RMW_RD,
        RMW_WR,
        ERR
    } state_t;

    state_t state, state_n;

    // registered request fields
    logic [DM_ADDR_W-1:0] waddr_q;
    logic [1:0]           off_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [31:0]          wdata_q;

    logic        accept;
    logic        req_err;
    logic        rsp_set;
    logic        rsp_err_n;
    logic [31:0] rsp_data_n;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    // byte-address bits above the memory's reach are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:DM_ADDR_W+2];

    // alignment / size legality of the incoming request
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_RSVD: req_err = 1'b1;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b0;
        endcase
    end

    // lane extraction with sign/zero extension, and sub-word store merge
    always_comb begin
        ld_byte = 8'h00;
        case (off_q)
            2'd0:    ld_byte = DM_out[7:0];
            2'd1:    ld_byte = DM_out[15:8];
            2'd2:    ld_byte = DM_out[23:16];
            default: ld_byte = DM_out[31:24];
        endcase
        ld_half = off_q[1] ? DM_out[31:16] : DM_out[15:0];

        case (size_q)
            SZ_BYTE: ld_ext = uns_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = uns_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = DM_out;
        endcase

        st_merge = DM_out;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0:    st_merge[7:0]   = wdata_q[7:0];
                2'd1:    st_merge[15:8]  = wdata_q[7:0];
                2'd2:    st_merge[23:16] = wdata_q[7:0];
                default: st_merge[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            st_merge[31:16] = wdata_q[15:0];
        end else begin
            st_merge[15:0] = wdata_q[15:0];
        end
    end

    // next state, memory port decode and response staging
    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        DM_read    = 1'b0;
        DM_write   = 1'b0;
        DM_addr    = '0;
        DM_in      = 32'h0000_0000;
        rsp_set    = 1'b0;
        rsp_err_n  = 1'b0;
        rsp_data_n = 32'h0000_0000;

        case (state)
            // ERR only exists for the cycle its response is visible; it accepts like IDLE
            IDLE, ERR: begin
                req_ready = 1'b1;
                if (state == ERR) DM_addr = waddr_q;
                state_n = IDLE;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_n   = ERR;
                        rsp_set   = 1'b1;
                        rsp_err_n = 1'b1;
                    end else if (!req_we) begin
                        state_n = LD_RD;
                    end else if (req_size == SZ_WORD) begin
                        state_n = ST_WR;
                    end else begin
                        state_n = RMW_RD;
                    end
                end
            end
            LD_RD: begin
                DM_read = 1'b1;
                DM_addr = waddr_q;
                state_n = LD_DATA;
            end
            LD_DATA: begin
                DM_addr    = waddr_q;
                rsp_set    = 1'b1;
                rsp_data_n = ld_ext;
                state_n    = IDLE;
            end
            ST_WR: begin
                DM_write = 1'b1;
                DM_addr  = waddr_q;
                DM_in    = wdata_q;
                rsp_set  = 1'b1;
                state_n  = IDLE;
            end
            RMW_RD: begin
                DM_read = 1'b1;
                DM_addr = waddr_q;
                state_n = RMW_WR;
            end
            RMW_WR: begin
                DM_write = 1'b1;
                DM_addr  = waddr_q;
                DM_in    = st_merge;
                rsp_set  = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= rsp_set;
            if (rsp_set) begin
                rsp_rdata <= rsp_data_n;
                rsp_err   <= rsp_err_n;
            end
        end
    end

    // capture request fields at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0000_0000;
        end else if (accept) begin
            waddr_q <= req_addr[DM_ADDR_W+1:2];
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

endmodule
